// File: rtl/gamepad_responder.sv
// NES/SNES controller emulator: answers a latch/clock serial reader with the
// button state, LSB first and active low. Pad pins are synchronised to clk.
module gamepad_responder #(
  parameter int SHIFT_BITS  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [SHIFT_BITS-1:0]         buttons,
  input  logic                          pad_latch,
  input  logic                          pad_clk,
  output logic                          pad_data,
  output logic                          frame_strobe,
  output logic                          frame_done,
  output logic [$clog2(SHIFT_BITS):0]   bit_index
);

  localparam int IW = $clog2(SHIFT_BITS) + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(SHIFT_BITS - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  lat_sync_q, pclk_sync_q;
  logic                    lat_prev_q, pclk_prev_q;
  logic [SHIFT_BITS-1:0]   sr_q, sr_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic                    pd_q, pd_d;
  logic                    fs_q, fs_d;
  logic                    fd_q, fd_d;

  logic lat_s, pclk_s, lat_fall, pclk_rise;

  assign lat_s     = lat_sync_q[SYNC_STAGES-1];
  assign pclk_s    = pclk_sync_q[SYNC_STAGES-1];
  assign lat_fall  = lat_prev_q & ~lat_s;
  assign pclk_rise = pclk_s & ~pclk_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_sync_q  <= '0;
      pclk_sync_q <= '0;
      lat_prev_q  <= 1'b0;
      pclk_prev_q <= 1'b0;
    end else begin
      lat_sync_q  <= {lat_sync_q[SYNC_STAGES-2:0], pad_latch};
      pclk_sync_q <= {pclk_sync_q[SYNC_STAGES-2:0], pad_clk};
      lat_prev_q  <= lat_s;
      pclk_prev_q <= pclk_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a synced latch high wins from every state
  always_comb begin
    state_d = state_q;
    if (lat_s) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    if (lat_fall) state_d = SHIFT;
        SHIFT:   if (pclk_rise && idx_q == LAST_IDX) state_d = DONE;
        default: ;
      endcase
    end
  end

  // Datapath and strobes
  always_comb begin
    sr_d  = sr_q;
    idx_d = idx_q;
    fs_d  = 1'b0;
    fd_d  = 1'b0;
    pd_d  = (state_q == IDLE || state_q == DONE) ? 1'b1 : sr_q[0];
    if (lat_s) begin
      sr_d  = ~buttons;
      idx_d = '0;
    end else begin
      case (state_q)
        LOAD:  fs_d = lat_fall;
        SHIFT: if (pclk_rise) begin
          sr_d  = {1'b1, sr_q[SHIFT_BITS-1:1]};
          idx_d = idx_q + 1'b1;
          fd_d  = (idx_q == LAST_IDX);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= '1;
      idx_q <= '0;
      pd_q  <= 1'b1;
      fs_q  <= 1'b0;
      fd_q  <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      idx_q <= idx_d;
      pd_q  <= pd_d;
      fs_q  <= fs_d;
      fd_q  <= fd_d;
    end
  end

  assign pad_data     = pd_q;
  assign frame_strobe = fs_q;
  assign frame_done   = fd_q;
  assign bit_index    = idx_q;

endmodule

// File: tb/tb_gamepad_responder.sv
// Bench for gamepad_responder: NES and SNES instances share the pad pins and
// reset; a frame-level model is checked every cycle, plus directed reads.
module tb_gamepad_responder;
  localparam int S  = 2;
  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pad_latch = 1'b0;
  logic        pad_clk = 1'b0;
  logic [7:0]  btn_n;
  logic [15:0] btn_s;
  logic        pd_n, fs_n, fd_n, pd_s, fs_s, fd_s;
  logic [3:0]  bi_n;
  logic [4:0]  bi_s;

  int checks = 0;
  int errors = 0;
  int cnt_fs_n = 0, cnt_fd_n = 0, cnt_fs_s = 0, cnt_fd_s = 0;
  logic [7:0]  got_n;
  logic [15:0] got_s;

  always #5 clk = ~clk;

  gamepad_responder #(.SHIFT_BITS(8), .SYNC_STAGES(S)) u_nes (
    .clk(clk), .rst_n(rst_n), .buttons(btn_n), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pd_n), .frame_strobe(fs_n), .frame_done(fd_n), .bit_index(bi_n));

  gamepad_responder #(.SHIFT_BITS(16), .SYNC_STAGES(S)) u_snes (
    .clk(clk), .rst_n(rst_n), .buttons(btn_s), .pad_latch(pad_latch), .pad_clk(pad_clk),
    .pad_data(pd_s), .frame_strobe(fs_s), .frame_done(fd_s), .bit_index(bi_s));

  // Frame model: a pin is seen S edges after it is sampled; the reader sees
  // word[idx] (active-low frame word) one edge after that.
  logic [S:0]  lat_h, clk_h;
  logic [15:0] m_word [2];
  int          m_idx  [2];
  int          m_phase[2];   // 0 idle, 1 latching, 2 shifting, 3 finished
  logic        m_pd[2], m_fs[2], m_fd[2];
  logic        L, Lp, C, Cp;

  assign L  = lat_h[S-1];
  assign Lp = lat_h[S];
  assign C  = clk_h[S-1];
  assign Cp = clk_h[S];

  function automatic int nbits(input int g);
    return (g == 0) ? 8 : 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_h <= '0;
      clk_h <= '0;
      for (int g = 0; g < 2; g++) begin
        m_word[g] <= '1; m_idx[g] <= 0; m_phase[g] <= 0;
        m_pd[g] <= 1'b1; m_fs[g] <= 1'b0; m_fd[g] <= 1'b0;
      end
    end else begin
      lat_h <= {lat_h[S-1:0], pad_latch};
      clk_h <= {clk_h[S-1:0], pad_clk};
      for (int g = 0; g < 2; g++) begin
        m_pd[g] <= (m_idx[g] < nbits(g)) ? m_word[g][m_idx[g]] : 1'b1;
        m_fs[g] <= 1'b0;
        m_fd[g] <= 1'b0;
        if (L) begin
          m_word[g]  <= (g == 0) ? {8'hFF, ~btn_n} : ~btn_s;
          m_idx[g]   <= 0;
          m_phase[g] <= 1;
        end else if (m_phase[g] == 1 && Lp) begin
          m_fs[g]    <= 1'b1;
          m_phase[g] <= 2;
        end else if (m_phase[g] == 2 && C && !Cp) begin
          m_idx[g] <= m_idx[g] + 1;
          if (m_idx[g] + 1 == nbits(g)) begin
            m_fd[g]    <= 1'b1;
            m_phase[g] <= 3;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t pd/fs/fd/idx got %b/%b/%b/%0d want %b/%b/%b/%0d", nm, $time,
               act[7], act[6], act[5], act[4:0], exp[7], exp[6], exp[5], exp[4:0]);
    end
  endtask

  always @(negedge clk) begin
    cmp("model_nes",  {pd_n, fs_n, fd_n, 1'b0, bi_n},
        {m_pd[0], m_fs[0], m_fd[0], 5'(m_idx[0])});
    cmp("model_snes", {pd_s, fs_s, fd_s, bi_s},
        {m_pd[1], m_fs[1], m_fd[1], 5'(m_idx[1])});
    if (fs_n) cnt_fs_n++;
    if (fd_n) cnt_fd_n++;
    if (fs_s) cnt_fs_s++;
    if (fd_s) cnt_fd_s++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic latch_pulse();
    pad_latch = 1'b1; tick(PH);
    pad_latch = 1'b0; tick(PH);
  endtask

  task automatic clk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      pad_clk = 1'b1; tick(PH);
      pad_clk = 1'b0; tick(PH);
    end
  endtask

  // Reader: sample bit 0 after the latch, then one bit after each rising
  // edge; nb edges in total so the last one shifts past the final bit.
  task automatic shift_read(input int nb);
    got_n = '1;
    got_s = '1;
    got_n[0] = pd_n;
    got_s[0] = pd_s;
    for (int i = 1; i <= nb; i++) begin
      pad_clk = 1'b1; tick(PH);
      if (i < nb) begin
        if (i < 8) got_n[i] = pd_n;
        got_s[i] = pd_s;
      end
      pad_clk = 1'b0; tick(PH);
    end
  endtask

  initial begin
    btn_n = 8'h85;
    btn_s = 16'h0A5C;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;

    tick(100);
    chk("idle_pd", pd_n, 1);
    chk("idle_idx", bi_n, 0);
    chk("idle_strobes", cnt_fs_n + cnt_fd_n + cnt_fs_s + cnt_fd_s, 0);

    // NES frame, buttons 1000_0101 -> data 0,1,0,1,1,1,1,0
    latch_pulse();
    shift_read(8);
    chk("nes_data", got_n, 8'h7A);
    chk("snes_low_byte", got_s[7:0], 8'hA3);
    chk("nes_strobe_cnt", cnt_fs_n, 1);
    chk("nes_done_cnt", cnt_fd_n, 1);
    chk("nes_after_pd", pd_n, 1);
    chk("nes_after_idx", bi_n, 8);

    // Overrun
    clk_pulses(4);
    chk("ovr_pd", pd_n, 1);
    chk("ovr_idx", bi_n, 8);
    chk("ovr_done_cnt", cnt_fd_n, 1);
    chk("ovr_snes_idx", bi_s, 12);

    // Re-latch after 3 shifts, buttons changed to FF while latched
    latch_pulse();
    clk_pulses(3);
    chk("relatch_pre_idx", bi_n, 3);
    pad_latch = 1'b1; tick(4);
    chk("relatch_idx", bi_n, 0);
    btn_n = 8'hFF;
    tick(4);
    pad_latch = 1'b0; tick(PH);
    shift_read(8);
    chk("relatch_data", got_n, 8'h00);
    chk("relatch_done_cnt", cnt_fd_n, 2);
    chk("relatch_strobe_cnt", cnt_fs_n, 3);

    // Latch and pad_clk rise together: no shift
    btn_n = 8'h01;
    pad_latch = 1'b1; pad_clk = 1'b1; tick(PH);
    pad_latch = 1'b0; tick(PH);
    chk("simul_first_pd", pd_n, 0);
    chk("simul_idx", bi_n, 0);
    pad_clk = 1'b0; tick(PH);
    pad_clk = 1'b1; tick(PH);
    chk("simul_next_idx", bi_n, 1);
    chk("simul_next_pd", pd_n, 1);
    pad_clk = 1'b0; tick(PH);

    // SNES full frame
    latch_pulse();
    shift_read(16);
    chk("snes_data", got_s, 16'hF5A3);
    chk("snes_idx", bi_s, 16);
    chk("snes_pd_after", pd_s, 1);

    // Async reset mid-frame
    latch_pulse();
    clk_pulses(5);
    chk("rst_pre_idx", bi_s, 5);
    rst_n = 1'b0;
    #1;
    chk("rst_pd", pd_s, 1);
    chk("rst_idx", bi_s, 0);
    chk("rst_nes_idx", bi_n, 0);
    tick(3);
    rst_n = 1'b1;
    tick(20);
    chk("post_rst_pd", pd_s, 1);
    chk("post_rst_idx", bi_s, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
